// File: rtl/mmap_m_axi_reg_slice_pipe.sv
// Chained valid/ready register slice: full (2-entry skid), forward, reverse or bypass per MODE.
// Optional beat/stall counters are built when MMAP_M_AXI_REG_SLICE_PIPE_STATS_EN is defined.
module mmap_m_axi_reg_slice_pipe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STAGES     = 1,
  parameter int unsigned MODE       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef MMAP_M_AXI_REG_SLICE_PIPE_STATS_EN
  ,
  input  logic                  stats_clear,
  output logic [31:0]           xfer_count,
  output logic [31:0]           stall_count
`endif
);

  // Handshake: a beat moves on an interface exactly when valid && ready at a rising clk edge;
  // a producer holds valid and data stable until that edge, and ready never waits on valid.

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  if (MODE == 3) begin : g_bypass
    assign s_ready = m_ready;
    assign m_valid = s_valid;
    assign m_data  = s_data;
  end else begin : g_chain
    // Link k feeds stage k; link STAGES is the downstream port.
    logic [STAGES:0][DATA_WIDTH-1:0] lnk_data;
    logic [STAGES:0]                 lnk_valid;
    logic [STAGES:0]                 lnk_ready;

    assign lnk_data[0]       = s_data;
    assign lnk_valid[0]      = s_valid;
    assign s_ready           = lnk_ready[0];
    assign m_data            = lnk_data[STAGES];
    assign m_valid           = lnk_valid[STAGES];
    assign lnk_ready[STAGES] = m_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [DATA_WIDTH-1:0] in_data;
      logic                  in_valid;
      logic                  out_ready;

      assign in_data   = lnk_data[k];
      assign in_valid  = lnk_valid[k];
      assign out_ready = lnk_ready[k+1];

      if (MODE == 0) begin : g_full
        state_t                state;
        logic [DATA_WIDTH-1:0] out_data;
        logic [DATA_WIDTH-1:0] skid;
        logic                  out_valid;
        logic                  in_ready;
        logic                  in_beat;

        assign in_beat = in_valid & in_ready;

        always_ff @(posedge clk) begin
          if (reset) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
          end else begin
            unique case (state)
              ST_EMPTY: begin
                in_ready <= 1'b1;
                if (in_beat) begin
                  out_data  <= in_data;
                  out_valid <= 1'b1;
                  state     <= ST_ONE;
                end
              end
              ST_ONE: begin
                if (in_beat && out_ready) begin
                  out_data <= in_data;
                end else if (in_beat) begin
                  skid     <= in_data;
                  in_ready <= 1'b0;
                  state    <= ST_TWO;
                end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_EMPTY;
                end
              end
              ST_TWO: begin
                // The held skid entry becomes the new head once the old head leaves.
                if (out_ready) begin
                  out_data <= skid;
                  in_ready <= 1'b1;
                  state    <= ST_ONE;
                end
              end
              default: begin
                state     <= ST_EMPTY;
                out_valid <= 1'b0;
                in_ready  <= 1'b0;
              end
            endcase
          end
        end

        assign lnk_ready[k]   = in_ready;
        assign lnk_valid[k+1] = out_valid;
        assign lnk_data[k+1]  = out_data;
      end else if (MODE == 1) begin : g_fwd
        logic [DATA_WIDTH-1:0] out_data;
        logic                  out_valid;
        logic                  in_ready;

        assign in_ready = ~out_valid | out_ready;

        always_ff @(posedge clk) begin
          if (reset) begin
            out_valid <= 1'b0;
          end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end

        assign lnk_ready[k]   = in_ready;
        assign lnk_valid[k+1] = out_valid;
        assign lnk_data[k+1]  = out_data;
      end else begin : g_rev
        logic [DATA_WIDTH-1:0] skid;
        logic                  skid_full;
        logic                  in_ready;

        always_ff @(posedge clk) begin
          if (reset) begin
            skid_full <= 1'b0;
            in_ready  <= 1'b0;
          end else if (skid_full) begin
            if (out_ready) begin
              skid_full <= 1'b0;
              in_ready  <= 1'b1;
            end
          end else begin
            in_ready <= 1'b1;
            if (in_valid && in_ready && !out_ready) begin
              skid      <= in_data;
              skid_full <= 1'b1;
              in_ready  <= 1'b0;
            end
          end
        end

        // Pass-through is gated by in_ready so nothing leaks out while reset holds it low.
        assign lnk_ready[k]   = in_ready;
        assign lnk_valid[k+1] = skid_full | (in_valid & in_ready);
        assign lnk_data[k+1]  = skid_full ? skid : in_data;
      end
    end
  end

`ifdef MMAP_M_AXI_REG_SLICE_PIPE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || stats_clear) begin
      xfer_count  <= '0;
      stall_count <= '0;
    end else begin
      if (m_valid && m_ready && (xfer_count != 32'hFFFF_FFFF))
        xfer_count <= xfer_count + 32'd1;
      if (m_valid && !m_ready && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
